// File: rtl/lsu_byte_master.sv
// lsu_byte_master: load/store initiator that splits a byte/half/word core
// request into sequential little-endian single-byte memory transactions,
// reassembles load data with sign/zero extension and returns a one-cycle
// response. The current FSM state is exported on dbg_state.
//
// Handshakes:
//   core side  - a request transfers on a rising edge where req_valid and
//                req_ready are both 1; req_ready is high only while idle.
//                The response is a single-cycle resp_valid pulse; resp_err
//                and resp_rdata are meaningful only during that pulse.
//   memory side - mem_en/mem_we/mem_addr/mem_wdata are registered and held
//                until an edge samples mem_ack = 1; that edge completes the
//                byte (mem_rdata is captured on it). mem_ack is ignored
//                while mem_en = 0.
module lsu_byte_master #(
    parameter int ADDR_LIMIT = 4096
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_digit,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state;
    logic        wr_q;
    logic        uns_q;
    logic [1:0]  dig_q;
    logic [1:0]  last_q;     // index of the final byte (nbytes - 1)
    logic [1:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] buf_q;

    logic [1:0]  req_last;
    logic [32:0] req_end;
    logic        req_bad;
    logic [31:0] buf_next;
    logic [1:0]  cnt_inc;

    assign dbg_state = state;

    // Extend the reassembled load value to 32 bits according to width.
    function automatic logic [31:0] extend(input logic [31:0] b,
                                           input logic [1:0]  dig,
                                           input logic        uns);
        case (dig)
            2'b00:   extend = {{24{~uns & b[7]}}, b[7:0]};
            2'b01:   extend = {{16{~uns & b[15]}}, b[15:0]};
            default: extend = b;
        endcase
    endfunction

    // Request decode: last byte index, 33-bit end address (so a wrap past
    // 0xFFFFFFFF is caught) and the buffer with the current byte merged in.
    always_comb begin
        case (req_digit)
            2'b00:   req_last = 2'd0;
            2'b01:   req_last = 2'd1;
            default: req_last = 2'd3;
        endcase
        req_end  = {1'b0, req_addr} + {31'b0, req_last};
        req_bad  = (req_digit == 2'b11) || (req_end >= 33'(ADDR_LIMIT));
        buf_next = buf_q;
        buf_next[{cnt, 3'b000} +: 8] = mem_rdata;
        cnt_inc  = cnt + 2'd1;
    end

    // Control FSM with registered core-side and memory-side outputs.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            wr_q       <= 1'b0;
            uns_q      <= 1'b0;
            dig_q      <= '0;
            last_q     <= '0;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            buf_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        wr_q      <= req_wr;
                        uns_q     <= req_unsigned;
                        dig_q     <= req_digit;
                        last_q    <= req_last;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        buf_q     <= '0;
                        cnt       <= '0;
                        req_ready <= 1'b0;
                        if (req_bad) begin
                            // Rejected requests never touch memory.
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state     <= ACCESS;
                            mem_en    <= 1'b1;
                            mem_we    <= req_wr;
                            mem_addr  <= req_addr;
                            mem_wdata <= req_wdata[7:0];
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        if (!wr_q) begin
                            buf_q <= buf_next;
                        end
                        if (cnt == last_q) begin
                            state      <= DONE;
                            mem_en     <= 1'b0;
                            mem_we     <= 1'b0;
                            mem_addr   <= '0;
                            mem_wdata  <= '0;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= wr_q ? 32'd0 : extend(buf_next, dig_q, uns_q);
                        end else begin
                            // Next byte follows immediately with mem_en held high.
                            cnt       <= cnt_inc;
                            mem_addr  <= addr_q + {30'b0, cnt_inc};
                            mem_wdata <= wdata_q[{cnt_inc, 3'b000} +: 8];
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    mem_en     <= 1'b0;
                    mem_we     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_byte_master.sv
// Testbench for lsu_byte_master: directed scenarios plus randomized requests,
// checked against a byte-array reference memory and an expected queue of
// memory transactions.
module tb_lsu_byte_master;

    localparam int ADDR_LIMIT = 4096;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [1:0]  req_digit = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [1:0]  dbg_state;

    lsu_byte_master #(.ADDR_LIMIT(ADDR_LIMIT)) dut (
        .CLK(CLK), .RST_n(RST_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_digit(req_digit), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- scoreboard state ----------------
    logic [7:0]  mem     [0:4095];   // memory seen by the DUT
    logic [7:0]  ref_mem [0:4095];   // reference model's memory
    logic [40:0] exp_q[$];           // {we, addr, wdata} per expected byte
    int          n_checks = 0;
    int          n_errors = 0;
    int          ack_delay_max = 0;
    bit          ack_rand = 1'b0;
    bit          holding = 1'b0;
    int          wait_left = 0;
    logic [40:0] cur_txn = '0;
    int          last_ready_wait = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    // Decides mem_ack for the current cycle at the falling edge; idle-time
    // ack is random noise that the DUT must ignore.
    always @(negedge CLK) begin
        if (RST_n && mem_en) begin
            if (!holding) begin
                if (exp_q.size() == 0) begin
                    check("mem_spurious", mem_en, 1'b0);
                end else begin
                    cur_txn = exp_q.pop_front();
                    check("mem_txn", {mem_we, mem_addr, mem_wdata}, cur_txn);
                end
                cur_txn   = {mem_we, mem_addr, mem_wdata};
                holding   = 1'b1;
                wait_left = ack_rand ? int'($urandom_range(0, ack_delay_max)) : ack_delay_max;
            end else begin
                check("mem_stable", {mem_we, mem_addr, mem_wdata}, cur_txn);
            end
            if (wait_left == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr[11:0]];
                if (mem_we) mem[mem_addr[11:0]] = mem_wdata;
                holding   = 1'b0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 8'($urandom);
                wait_left--;
            end
        end else begin
            if (RST_n && holding) check("mem_en_held", mem_en, 1'b1);
            holding   = 1'b0;
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = 8'($urandom);
        end
    end

    // ---------------- driver + reference model ----------------
    // Called just after a falling edge; returns at the falling edge of the
    // cycle following the response pulse.
    task automatic do_req(input bit wr, input bit [1:0] dig, input bit uns,
                          input bit [31:0] addr, input bit [31:0] wdata,
                          input bit keep, input string tag);
        int              n;
        int              lat;
        bit              err;
        longint unsigned a;
        logic [31:0]     val;
        req_valid    = 1'b1;
        req_wr       = wr;
        req_digit    = dig;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        last_ready_wait = 0;
        while (!req_ready && last_ready_wait < 50) begin
            @(negedge CLK);
            last_ready_wait++;
        end
        if (!req_ready) check({tag, "_accept_timeout"}, req_ready, 1'b1);

        // Reference model: byte count, range rule, byte stream, result.
        n   = (dig == 2'b00) ? 1 : (dig == 2'b01) ? 2 : 4;
        a   = addr;
        err = (dig == 2'b11) || (a + longint'(n) - 1 >= ADDR_LIMIT);
        val = '0;
        if (!err) begin
            for (int k = 0; k < n; k++) begin
                logic [31:0] ba;
                ba = addr + k;
                exp_q.push_back({wr, ba, wdata[8*k +: 8]});
                if (wr) ref_mem[ba[11:0]] = wdata[8*k +: 8];
                else    val = val | (32'(ref_mem[ba[11:0]]) << (8*k));
            end
        end
        if (!wr && n < 4 && !uns && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8*n));
        if (wr || err) val = '0;

        @(posedge CLK);
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
            if (lat == 1 && !keep) req_valid = 1'b0;
        end while (!resp_valid && lat < 400);
        check({tag, "_resp_valid"}, resp_valid, 1'b1);
        check({tag, "_resp_err"}, resp_err, err);
        check({tag, "_resp_rdata"}, resp_rdata, val);
        if (!ack_rand && ack_delay_max == 0)
            check({tag, "_latency"}, lat, err ? 1 : n + 1);
        @(negedge CLK);
        check({tag, "_pulse_end"}, {resp_valid, resp_err, resp_rdata}, 34'd0);
        check({tag, "_ready_back"}, req_ready, 1'b1);
        check({tag, "_bytes_done"}, exp_q.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        repeat (3) @(negedge CLK);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp", {resp_valid, resp_err, resp_rdata}, 34'd0);
        check("rst_mem_ctl", {mem_en, mem_we}, 2'b00);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 8'd0);
        check("rst_state", dbg_state, 2'd0);
        RST_n = 1'b1;
        @(negedge CLK);

        // Word store then load, ack tied high.
        do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, 1'b0, "st_word");
        do_req(1'b0, 2'b10, 1'b0, 32'h100, $urandom, 1'b0, "ld_word");

        // Extension cases.
        mem[16] = 8'h80; ref_mem[16] = 8'h80;
        mem[17] = 8'h7F; ref_mem[17] = 8'h7F;
        do_req(1'b0, 2'b00, 1'b0, 32'h10, $urandom, 1'b0, "ld_sbyte");
        do_req(1'b0, 2'b00, 1'b1, 32'h10, $urandom, 1'b0, "ld_ubyte");
        do_req(1'b0, 2'b01, 1'b0, 32'h10, $urandom, 1'b0, "ld_shalf_pos");
        mem[16] = 8'h00; ref_mem[16] = 8'h00;
        mem[17] = 8'h80; ref_mem[17] = 8'h80;
        do_req(1'b0, 2'b01, 1'b0, 32'h10, $urandom, 1'b0, "ld_shalf_neg");
        do_req(1'b0, 2'b01, 1'b1, 32'h10, $urandom, 1'b0, "ld_uhalf");

        // Wait states on a misaligned half store.
        ack_delay_max = 3;
        do_req(1'b1, 2'b01, 1'b0, 32'h203, 32'h1234_ABCD, 1'b0, "st_half_wait");
        do_req(1'b0, 2'b10, 1'b0, 32'h200, $urandom, 1'b0, "ld_word_wait");
        ack_delay_max = 0;

        // Range and illegal-width errors, plus in-range boundary accesses.
        do_req(1'b0, 2'b10, 1'b0, 32'hFFE, $urandom, 1'b0, "err_word_ffe");
        do_req(1'b0, 2'b11, 1'b0, 32'h100, $urandom, 1'b0, "err_digit");
        do_req(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, $urandom, 1'b0, "err_wrap");
        do_req(1'b1, 2'b01, 1'b0, 32'hFFF, $urandom, 1'b0, "err_half_fff");
        do_req(1'b0, 2'b10, 1'b1, 32'hFFC, $urandom, 1'b0, "ok_word_ffc");
        do_req(1'b1, 2'b00, 1'b0, 32'hFFF, $urandom, 1'b0, "ok_byte_fff");

        // Reset in the middle of a word store after two bytes complete.
        req_valid = 1'b1; req_wr = 1'b1; req_digit = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h300; req_wdata = 32'hCAFE_F00D;
        exp_q.push_back({1'b1, 32'h300, 8'h0D});
        exp_q.push_back({1'b1, 32'h301, 8'hF0});
        ref_mem[12'h300] = 8'h0D;
        ref_mem[12'h301] = 8'hF0;
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1 RST_n = 1'b0;
        #1;
        check("rst_mid_ready", req_ready, 1'b1);
        check("rst_mid_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 42'd0);
        check("rst_mid_resp", {resp_valid, resp_err, resp_rdata}, 34'd0);
        check("rst_mid_state", dbg_state, 2'd0);
        @(negedge CLK);
        RST_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("rst_no_resp", resp_valid, 1'b0);
        end
        check("rst_bytes_written", exp_q.size(), 0);
        do_req(1'b0, 2'b00, 1'b1, 32'h301, $urandom, 1'b0, "rst_after_ld");
        do_req(1'b0, 2'b10, 1'b1, 32'h300, $urandom, 1'b0, "rst_partial_word");

        // Back-to-back byte loads with req_valid held high throughout.
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, 2'b00, 1'(i), 32'h40 + 32'(i), $urandom, i < 3, "b2b");
            if (i > 0) check("b2b_accept_wait", last_ready_wait, 0);
        end

        // Randomized requests with random wait states.
        ack_rand = 1'b1;
        ack_delay_max = 2;
        for (int i = 0; i < 60; i++) begin
            int          sel;
            logic [31:0] ra;
            sel = int'($urandom_range(0, 9));
            if (sel < 8)       ra = 32'($urandom_range(0, 4100));
            else if (sel == 8) ra = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else               ra = 32'($urandom_range(4090, 4095));
            do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), ra, $urandom, 1'b0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
